// File: rtl/note_key_select.sv
// note_key_select
//   Converts eight raw piano-key buttons into the one-hot note enables that
//   drive the per-note tone generators (bit 0 = C ... bit 7 = C2).
//   Each key is synchronised (two flops) and debounced. A small FSM then
//   selects one active note with last-pressed priority. After the last key
//   is let go, the note is held for a release tail so that short taps
//   remain audible.
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-high reset
//   keys_raw   in   raw button levels, active-high, asynchronous to clk
//   keys_db    out  debounced key levels (registered)
//   note_en    out  one-hot note enable; all-zero when silent
//   note_idx   out  index of the active note, valid when note_valid=1
//   note_valid out  high when any note_en bit is set
module note_key_select #(
    parameter int NUM_KEYS        = 8,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int RELEASE_CYCLES  = 2500000,
    parameter int CNT_W           = 22
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] keys_raw,
    output logic [NUM_KEYS-1:0] keys_db,
    output logic [NUM_KEYS-1:0] note_en,
    output logic [2:0]          note_idx,
    output logic                note_valid
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PLAY    = 2'd1,
        SUSTAIN = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Two-stage synchroniser
    // ------------------------------------------------------------------
    logic [NUM_KEYS-1:0] sync1_q;
    logic [NUM_KEYS-1:0] sync2_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= keys_raw;
            sync2_q <= sync1_q;
        end
    end

    // ------------------------------------------------------------------
    // Per-key debouncer
    // The counter only runs while the synchronised level disagrees with the
    // accepted level. Any agreeing cycle restarts it, so a glitch must last
    // a full DEBOUNCE_CYCLES before it can flip keys_db.
    // ------------------------------------------------------------------
    logic [NUM_KEYS-1:0] db_q;

    for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_debounce
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;
        logic             key_q;
        logic             key_d;

        always_comb begin
            cnt_d = '0;
            key_d = key_q;
            if (sync2_q[gi] != key_q) begin
                if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    key_d = ~key_q;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                cnt_q <= '0;
                key_q <= 1'b0;
            end else begin
                cnt_q <= cnt_d;
                key_q <= key_d;
            end
        end

        assign db_q[gi] = key_q;
    end

    assign keys_db = db_q;

    // ------------------------------------------------------------------
    // Registered press / release edge detectors
    // ------------------------------------------------------------------
    logic [NUM_KEYS-1:0] db_prev_q;
    logic [NUM_KEYS-1:0] press_q;
    logic [NUM_KEYS-1:0] release_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            db_prev_q <= '0;
            press_q   <= '0;
            release_q <= '0;
        end else begin
            db_prev_q <= db_q;
            press_q   <= db_q & ~db_prev_q;
            release_q <= ~db_q & db_prev_q;
        end
    end

    // Highest set bit wins; used both for simultaneous presses and for
    // falling back to a still-held key.
    function automatic logic [2:0] hi_idx(input logic [NUM_KEYS-1:0] v);
        logic [2:0] r;
        r = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (v[i]) r = 3'(i);
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Note selection FSM
    // ------------------------------------------------------------------
    state_t              state_q;
    state_t              state_d;
    logic [2:0]          idx_q;
    logic [2:0]          idx_d;
    logic [CNT_W-1:0]    rel_cnt_q;
    logic [CNT_W-1:0]    rel_cnt_d;
    logic [NUM_KEYS-1:0] en_q;
    logic [NUM_KEYS-1:0] en_d;
    logic                valid_q;
    logic                valid_d;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        rel_cnt_d = rel_cnt_q;

        case (state_q)
            IDLE: begin
                if (|press_q) begin
                    state_d = PLAY;
                    idx_d   = hi_idx(press_q);
                end
            end
            PLAY: begin
                // A new press takes priority over a simultaneous release
                // of the active key.
                if (|press_q) begin
                    idx_d = hi_idx(press_q);
                end else if (release_q[idx_q]) begin
                    if (|db_q) begin
                        idx_d = hi_idx(db_q);
                    end else begin
                        state_d   = SUSTAIN;
                        rel_cnt_d = '0;
                    end
                end
            end
            SUSTAIN: begin
                if (|press_q) begin
                    state_d = PLAY;
                    idx_d   = hi_idx(press_q);
                end else if (rel_cnt_q == CNT_W'(RELEASE_CYCLES - 1)) begin
                    state_d = IDLE;
                end else begin
                    rel_cnt_d = rel_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are derived from the next state so that note_en, note_idx
        // and note_valid all update on the same edge and a note switch
        // never passes through a silent or multi-hot value.
        en_d    = '0;
        valid_d = 1'b0;
        if (state_d != IDLE) begin
            en_d[idx_d] = 1'b1;
            valid_d     = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            rel_cnt_q <= '0;
            en_q      <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            rel_cnt_q <= rel_cnt_d;
            en_q      <= en_d;
            valid_q   <= valid_d;
        end
    end

    assign note_en    = en_q;
    assign note_idx   = idx_q;
    assign note_valid = valid_q;

endmodule

// File: doc/note_key_select.md
Name: note_key_select

Overview:
- Front-end stage that converts eight raw piano-key buttons into the one-hot note enables consumed by the per-note tone generators (C, D, E, F, G, A, B, C2).
- Synchronises and debounces each key, then picks a single active note with last-pressed priority.
- Holds the note for a release tail after the key is let go, so short taps stay audible.
- Clock is the 25 MHz system clock shared with the tone generators.

Parameters:
- NUM_KEYS, 8, number of keys/notes; bit 0 = C ... bit 7 = C2.
- DEBOUNCE_CYCLES, 250000, consecutive stable cycles required to accept a level change (10 ms at 25 MHz).
- RELEASE_CYCLES, 2500000, cycles the note stays enabled after its key releases (100 ms).
- CNT_W, 22, width of the debounce and release counters; must hold max(DEBOUNCE_CYCLES, RELEASE_CYCLES).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- keys_raw  input  NUM_KEYS  raw button levels, active-high, asynchronous to clk.
- keys_db  output  NUM_KEYS  debounced key levels (registered).
- note_en  output  NUM_KEYS  one-hot enable to the tone generators; all-zero when silent.
- note_idx  output  3  index of the active note; valid when note_valid=1.
- note_valid  output  1  high when any note_en bit is set.

Behaviour:
- Reset (async, active-high) clears all of the following immediately: synchronisers, debounce counters, keys_db, release counter, note_en, note_idx, note_valid. FSM goes to IDLE. Reset asserted mid-note silences the output in the same cycle.
- Synchroniser: two flip-flop stages per key feed the debouncer.
- Debounce, per key:
  - A counter increments while the synchronised level differs from keys_db.
  - The counter clears to 0 on any cycle where the two match.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, keys_db toggles on the next edge and the counter clears.
  - Glitches shorter than DEBOUNCE_CYCLES are never reflected on keys_db.
- Press edge = keys_db rises. Release edge = keys_db falls. Both are registered edge detectors.
- FSM states are IDLE, PLAY and SUSTAIN.
- IDLE:
  - note_en = 0.
  - Any press edge: go to PLAY, note_idx = the pressed key. If several keys see a press edge in the same cycle, the highest index wins.
- PLAY:
  - note_en = one-hot(note_idx).
  - A press edge on any key switches note_idx to that key (highest index on ties). Stay in PLAY.
  - Release of the active key while other keys are still held: note_idx = highest-index held key. Stay in PLAY.
  - Release of the active key with no keys held: go to SUSTAIN and load the release counter with 0.
  - Release of a non-active key: no effect.
  - A press edge and a release of the active key in the same cycle: the press wins.
- SUSTAIN:
  - note_en unchanged.
  - The counter increments each cycle. On reaching RELEASE_CYCLES-1, go to IDLE next edge and clear note_en/note_valid.
  - A press edge in SUSTAIN goes to PLAY with the new note and abandons the counter. The same key is allowed (retrigger).
- Output timing:
  - note_en, note_idx and note_valid are registered and change together.
  - Latency from a clean raw rising level to note_en is exactly DEBOUNCE_CYCLES+4 clk edges: 2 synchroniser edges, DEBOUNCE_CYCLES counter edges, 1 edge-detect, 1 FSM update.
  - note_en is never multi-hot and never glitches between notes; a switch happens on one edge.
- Keys held through reset deassertion are debounced from keys_db=0 and appear as fresh presses.
- Counters never wrap: the debounce counter is bounded by the clear, the release counter by the state exit.

Test Plan:
- DEBOUNCE_CYCLES=4, RELEASE_CYCLES=10, reset pulse, keys_raw=0 -> all outputs 0, note_valid=0.
- Raise keys_raw[2] and hold -> keys_db[2] rises 6 edges after the input change; note_en=8'b00000100, note_idx=2, note_valid=1 exactly 8 edges after the change. A 3-cycle pulse on keys_raw[5] -> no change on keys_db or note_en.
- Hold key 2; press key 6 -> note_en=8'b01000000. Release key 6 -> note_en returns to 8'b00000100. Release key 2 -> SUSTAIN: note_en stays 8'b00000100 for 10 cycles after keys_db[2] falls, then 0.
- Press keys 1 and 4 on the same cycle -> note_idx=4. Press key 0 during SUSTAIN of key 4 -> note_en=8'b00000001 on the press-edge cycle, no silent gap.
- Assert reset while note_en=8'b00010000 -> note_en=0 in the same cycle, before any clk edge. Deassert reset with key 4 still held -> replay after DEBOUNCE_CYCLES+4 edges, note_idx=4.
